// File: rtl/misr_multi.sv
// misr_multi: multi-channel MISR for LBIST response compaction.
// Hashes lockstep CUT beats into one signature; returns it on val/rdy.
module misr_multi #(
  parameter int NUM_CHANNELS        = 4,
  parameter int CUT_MSG_BITS        = 32,
  parameter int SIGNATURE_BITS      = 32,
  parameter logic [SIGNATURE_BITS-1:0] POLY = 32'h04C11DB7,
  parameter logic [SIGNATURE_BITS-1:0] SEED = '0,
  parameter int MAX_OUTPUTS_TO_HASH = 32,
  parameter int LBIST_MSG_BITS      = $clog2(MAX_OUTPUTS_TO_HASH)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                cut_req_val,
  input  logic [NUM_CHANNELS*CUT_MSG_BITS-1:0]   cut_req_msg,
  output logic [NUM_CHANNELS-1:0]                cut_req_rdy,
  input  logic                                   lbist_req_val,
  input  logic [LBIST_MSG_BITS:0]                lbist_req_msg,
  output logic                                   lbist_req_rdy,
  output logic                                   lbist_resp_val,
  output logic [SIGNATURE_BITS-1:0]              lbist_resp_msg,
  input  logic                                   lbist_resp_rdy
);

  localparam int SB = SIGNATURE_BITS;
  localparam int CW = LBIST_MSG_BITS + 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTPUTS_TO_HASH);

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SB-1:0] sig;
  logic [SB-1:0] sig_nxt;
  logic [SB-1:0] fold;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] req_cnt;
  logic          all_val;

  function automatic logic [SB-1:0] rotl(
    input logic [SB-1:0] x,
    input int            r
  );
    return (x << r) | (x >> (SB - r));
  endfunction

  assign all_val = &cut_req_val;
  assign req_cnt = (lbist_req_msg > CMAX) ? CMAX : lbist_req_msg;

  // Channel i is rotated left by i before XOR so equal channels do not cancel.
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      fold = fold ^ rotl(SB'(cut_req_msg[i*CUT_MSG_BITS +: CUT_MSG_BITS]),
                         i % SB);
    end
  end

  // Next-state, signature and count update.
  always_comb begin
    state_nxt = state;
    sig_nxt   = sig;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (lbist_req_val) begin
          cnt_nxt   = req_cnt;
          state_nxt = (req_cnt == '0) ? DONE : HASH;
        end
      end
      HASH: begin
        if (all_val) begin
          sig_nxt = (sig << 1) ^ (sig[SB-1] ? POLY : '0) ^ fold;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CW'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (lbist_resp_rdy) begin
          sig_nxt   = SEED;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, signature and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sig   <= SEED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sig   <= sig_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request ready is masked while reset is held so all outputs read 0.
  assign lbist_req_rdy  = reset && (state == IDLE);
  assign cut_req_rdy    = {NUM_CHANNELS{(state == HASH) && all_val}};
  assign lbist_resp_val = (state == DONE);
  assign lbist_resp_msg = sig;

endmodule

// File: tb/tb_misr_multi.sv
// tb_misr_multi: directed + random checks of misr_multi.
// Reference signature computed as GF(2) polynomial arithmetic.
module tb_misr_multi;

  localparam int NC  = 2;
  localparam int CMB = 8;
  localparam int SB  = 8;
  localparam int MAX = 4;
  localparam int LB  = $clog2(MAX);
  localparam logic [7:0] POLY = 8'h1D;
  localparam logic [7:0] SEED = 8'h00;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   cut_req_val;
  logic [NC*CMB-1:0] cut_req_msg;
  logic [NC-1:0]   cut_req_rdy;
  logic            lbist_req_val;
  logic [LB:0]     lbist_req_msg;
  logic            lbist_req_rdy;
  logic            lbist_resp_val;
  logic [SB-1:0]   lbist_resp_msg;
  logic            lbist_resp_rdy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] dir0 [8];
  logic [7:0] dir1 [8];

  misr_multi #(
    .NUM_CHANNELS(NC),
    .CUT_MSG_BITS(CMB),
    .SIGNATURE_BITS(SB),
    .POLY(POLY),
    .SEED(SEED),
    .MAX_OUTPUTS_TO_HASH(MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cut_req_val(cut_req_val),
    .cut_req_msg(cut_req_msg),
    .cut_req_rdy(cut_req_rdy),
    .lbist_req_val(lbist_req_val),
    .lbist_req_msg(lbist_req_msg),
    .lbist_req_rdy(lbist_req_rdy),
    .lbist_resp_val(lbist_resp_val),
    .lbist_resp_msg(lbist_resp_msg),
    .lbist_resp_rdy(lbist_resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sig*x mod (x^8 + POLY), plus channel fold with ch1 rotated by one.
  function automatic int model_step(input int s, input int a, input int b);
    int f;
    int t;
    f = a ^ (((b * 2) + (b / 128)) % 256);
    t = s * 2;
    if (t > 255) t = (t - 256) ^ int'(POLY);
    return t ^ f;
  endfunction

  task automatic run_op(input int count, input int delay, input int stall,
                        input bit directed, input int exp_final);
    int eff;
    int m;
    logic [7:0] a;
    logic [7:0] b;
    eff = (count > MAX) ? MAX : count;
    m = int'(SEED);
    @(negedge clk);
    check("req_rdy_idle", lbist_req_rdy, 1);
    lbist_req_val = 1'b1;
    lbist_req_msg = count[LB:0];
    @(negedge clk);
    lbist_req_val = 1'b0;
    check("resp_val_after_req", lbist_resp_val, eff == 0);
    check("req_rdy_busy", lbist_req_rdy, 0);
    for (int i = 0; i < eff; i++) begin
      a = directed ? dir0[i] : 8'($urandom);
      b = directed ? dir1[i] : 8'($urandom);
      for (int s = 0; s < stall; s++) begin
        cut_req_val = 2'b01;
        cut_req_msg = {b, a};
        #1 check("stall_rdy", cut_req_rdy, 0);
        @(negedge clk);
        check("stall_sig", lbist_resp_msg, m);
        check("stall_val", lbist_resp_val, 0);
      end
      cut_req_val = 2'b11;
      cut_req_msg = {b, a};
      #1 check("beat_rdy", cut_req_rdy, 2'b11);
      @(negedge clk);
      m = model_step(m, a, b);
      check("sig", lbist_resp_msg, m);
      check("resp_val", lbist_resp_val, i == eff - 1);
    end
    cut_req_val = 2'b11;
    cut_req_msg = 16'($urandom);
    #1 check("done_cut_rdy", cut_req_rdy, 0);
    check("done_val", lbist_resp_val, 1);
    check("done_msg", lbist_resp_msg, m);
    if (exp_final >= 0) check("final_const", lbist_resp_msg, exp_final);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check("hold_val", lbist_resp_val, 1);
      check("hold_msg", lbist_resp_msg, m);
    end
    lbist_resp_rdy = 1'b1;
    @(negedge clk);
    lbist_resp_rdy = 1'b0;
    cut_req_val = 2'b00;
    check("post_req_rdy", lbist_req_rdy, 1);
    check("post_val", lbist_resp_val, 0);
    check("post_seed", lbist_resp_msg, SEED);
  endtask

  initial begin
    reset          = 1'b0;
    cut_req_val    = '0;
    cut_req_msg    = '0;
    lbist_req_val  = 1'b0;
    lbist_req_msg  = '0;
    lbist_resp_rdy = 1'b0;
    #12;
    check("rst_req_rdy", lbist_req_rdy, 0);
    check("rst_resp_val", lbist_resp_val, 0);
    check("rst_cut_rdy", cut_req_rdy, 0);
    check("rst_msg", lbist_resp_msg, SEED);
    @(negedge clk);
    reset = 1'b1;

    dir0[0] = 8'h01; dir1[0] = 8'h01;
    run_op(1, 0, 0, 1'b1, 8'h03);

    dir0[0] = 8'h01; dir1[0] = 8'h01;
    dir0[1] = 8'h80; dir1[1] = 8'h00;
    dir0[2] = 8'h00; dir1[2] = 8'h00;
    run_op(3, 0, 0, 1'b1, 8'h11);

    run_op(0, 0, 0, 1'b0, 8'h00);

    dir0[0] = 8'h01; dir1[0] = 8'h01;
    run_op(1, 0, 3, 1'b1, 8'h03);

    run_op(3, 5, 0, 1'b0, -1);

    run_op(7, 1, 0, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'b0, -1);
    end

    @(negedge clk);
    lbist_req_val = 1'b1;
    lbist_req_msg = 3'd4;
    @(negedge clk);
    lbist_req_val = 1'b0;
    cut_req_val   = 2'b11;
    cut_req_msg   = 16'h5AA5;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_msg", lbist_resp_msg, SEED);
    check("mid_rst_val", lbist_resp_val, 0);
    check("mid_rst_cut", cut_req_rdy, 0);
    check("mid_rst_req", lbist_req_rdy, 0);
    cut_req_val = 2'b00;
    #2 reset = 1'b1;
    #1 check("mid_rst_idle", lbist_req_rdy, 1);
    dir0[0] = 8'h01; dir1[0] = 8'h01;
    run_op(1, 0, 0, 1'b1, 8'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
